// File: rtl/mux_rr_nx1_pkg.sv
// Shared definitions for the N-to-1 lane multiplexer: mode encodings, defaults, clog2.
// No logic; no latency; no flow control.
// Imported by the lane FIFO and the scheduler.
package mux_defs;

    localparam logic MODO_RR  = 1'b0;
    localparam logic MODO_TDM = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LANES = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_nx1_lane_fifo.sv
// Per-lane FIFO, DEPTH entries, with a wrap bit on each pointer to tell full from empty.
// Latency: a word pushed at edge k is visible on dout after edge k (no same-cycle bypass).
// Backpressure: none internally; the caller must not push when full or pop when empty.
module lane_fifo
    import mux_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mux_rr_nx1.sv
// N-to-1 lane mux: per-lane FIFOs drained by a round-robin or fixed-slot TDM scheduler.
// Latency: 2 cycles input to Salida (push at edge k, popped and registered at edge k+1).
// Backpressure: none; writes to a full lane are dropped and flagged in sticky overflow.
module mux_rr_nx1
    import mux_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = 4
) (
    input  logic                     clk_4f,
    input  logic                     reset,
    input  logic [LANES*WIDTH-1:0]   Entrada,
    input  logic [LANES-1:0]         validEntrada,
    input  logic                     modo_tdm,
    output logic [WIDTH-1:0]         Salida,
    output logic                     validsalida,
    output logic [clog2(LANES)-1:0]  lane_id,
    output logic [LANES-1:0]         full,
    output logic [LANES-1:0]         overflow
);

    localparam int LW = clog2(LANES);

    logic [LANES-1:0] push;
    logic [LANES-1:0] pop;
    logic [LANES-1:0] empty;
    logic [WIDTH-1:0] lane_dout [LANES];

    logic [LW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] salida_q, salida_d;
    logic             vld_q, vld_d;
    logic [LW-1:0]    lane_id_q, lane_id_d;
    logic [LANES-1:0] ovf_q, ovf_d;

    logic [LW-1:0]    pick;
    logic             pick_vld;

    function automatic logic [LW-1:0] nxt(input logic [LW-1:0] p);
        return (p == LW'(LANES - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign push[g] = validEntrada[g] & ~full[g];

        lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk_4f),
            .rst_n (reset),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (Entrada[g*WIDTH +: WIDTH]),
            .dout  (lane_dout[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    // Lane selection: TDM owns the slot at ptr; round-robin takes the first
    // non-empty lane at or after ptr.
    always_comb begin
        int            idx;
        logic [LW-1:0] cand;
        pick     = ptr_q;
        pick_vld = 1'b0;
        idx      = 0;
        cand     = '0;
        if (modo_tdm == MODO_TDM) begin
            pick_vld = ~empty[ptr_q];
        end else begin
            for (int off = 0; off < LANES; off++) begin
                idx = int'(ptr_q) + off;
                if (idx >= LANES) idx = idx - LANES;
                cand = LW'(idx);
                if (!pick_vld && !empty[cand]) begin
                    pick_vld = 1'b1;
                    pick     = cand;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop[i] = pick_vld && (pick == LW'(i));
        end
    end

    always_comb begin
        salida_d  = salida_q;
        vld_d     = pick_vld;
        lane_id_d = lane_id_q;
        ptr_d     = ptr_q;
        ovf_d     = ovf_q | (validEntrada & full);
        if (pick_vld) salida_d = lane_dout[pick];
        if (modo_tdm == MODO_TDM) begin
            lane_id_d = ptr_q;
            ptr_d     = nxt(ptr_q);
        end else if (pick_vld) begin
            lane_id_d = pick;
            ptr_d     = nxt(pick);
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            ptr_q     <= '0;
            salida_q  <= '0;
            vld_q     <= 1'b0;
            lane_id_q <= '0;
            ovf_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            salida_q  <= salida_d;
            vld_q     <= vld_d;
            lane_id_q <= lane_id_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Salida      = salida_q;
    assign validsalida = vld_q;
    assign lane_id     = lane_id_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Randomised and directed bench for mux_rr_nx1 with a queue-based lane model and scoreboard.
module tb_mux_rr_nx1;

    localparam int W = 8;
    localparam int L = 4;
    localparam int D = 4;

    logic            clk_4f;
    logic            reset;
    logic [L*W-1:0]  Entrada;
    logic [L-1:0]    validEntrada;
    logic            modo_tdm;
    logic [W-1:0]    Salida;
    logic            validsalida;
    logic [1:0]      lane_id;
    logic [L-1:0]    full;
    logic [L-1:0]    overflow;

    int total = 0;
    int bad   = 0;

    mux_rr_nx1 #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
        .clk_4f       (clk_4f),
        .reset        (reset),
        .Entrada      (Entrada),
        .validEntrada (validEntrada),
        .modo_tdm     (modo_tdm),
        .Salida       (Salida),
        .validsalida  (validsalida),
        .lane_id      (lane_id),
        .full         (full),
        .overflow     (overflow)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [1:0] id;
        logic [3:0] f;
        logic [3:0] o;
    } exp_t;

    exp_t sb[$];

    // Reference model: one queue per lane, a scan pointer, last-output holders.
    logic [7:0] mq [L][$];
    int         m_ptr;
    logic [7:0] m_d;
    logic [1:0] m_id;
    logic [3:0] m_ovf;

    task automatic model_clear();
        for (int i = 0; i < L; i++) mq[i].delete();
        m_ptr = 0;
        m_d   = '0;
        m_id  = '0;
        m_ovf = '0;
    endtask

    always @(posedge clk_4f) begin
        if (!reset) begin
            model_clear();
        end else begin
            exp_t e;
            int   pre [L];
            int   sel;
            sel = -1;
            for (int i = 0; i < L; i++) pre[i] = mq[i].size();
            if (modo_tdm) begin
                if (pre[m_ptr] > 0) sel = m_ptr;
                m_id  = 2'(m_ptr);
                m_ptr = (m_ptr + 1) % L;
            end else begin
                for (int off = 0; off < L; off++) begin
                    if (sel < 0 && pre[(m_ptr + off) % L] > 0) sel = (m_ptr + off) % L;
                end
                if (sel >= 0) begin
                    m_id  = 2'(sel);
                    m_ptr = (sel + 1) % L;
                end
            end
            e.v = (sel >= 0);
            if (sel >= 0) m_d = mq[sel].pop_front();
            for (int i = 0; i < L; i++) begin
                if (validEntrada[i]) begin
                    if (pre[i] >= D) m_ovf[i] = 1'b1;
                    else mq[i].push_back(Entrada[i*W +: W]);
                end
            end
            e.d  = m_d;
            e.id = m_id;
            e.o  = m_ovf;
            for (int i = 0; i < L; i++) e.f[i] = (mq[i].size() == D);
            sb.push_back(e);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs each cycle against the oldest expectation.
    always @(negedge clk_4f) begin
        if (!reset) begin
            sb.delete();
            check("rst_vld", 32'(validsalida), 0);
            check("rst_dat", 32'(Salida), 0);
            check("rst_id", 32'(lane_id), 0);
            check("rst_full", 32'(full), 0);
            check("rst_ovf", 32'(overflow), 0);
        end else if (sb.size() == 0) begin
            check("idle_vld", 32'(validsalida), 0);
            check("idle_id", 32'(lane_id), 0);
        end else begin
            exp_t e;
            e = sb.pop_front();
            check("vld", 32'(validsalida), 32'(e.v));
            check("dat", 32'(Salida), 32'(e.d));
            check("lane_id", 32'(lane_id), 32'(e.id));
            check("full", 32'(full), 32'(e.f));
            check("overflow", 32'(overflow), 32'(e.o));
        end
    end

    task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic m);
        @(posedge clk_4f);
        #2;
        validEntrada = v;
        Entrada      = d;
        modo_tdm     = m;
    endtask

    task automatic idle(input int n, input logic m);
        for (int i = 0; i < n; i++) cyc(4'h0, $urandom, m);
    endtask

    task automatic set_rst(input logic r);
        @(posedge clk_4f);
        #2;
        reset = r;
    endtask

    initial begin
        reset        = 1'b0;
        validEntrada = '0;
        Entrada      = '0;
        modo_tdm     = 1'b0;

        // Reset held with random inputs, then a quiet period.
        for (int i = 0; i < 5; i++) cyc(4'($urandom), $urandom, 1'($urandom));
        cyc(4'h0, 32'h0, 1'b0);
        set_rst(1'b1);
        idle(10, 1'b0);

        // Round-robin, all four lanes in one cycle.
        cyc(4'hF, 32'h4030_2010, 1'b0);
        idle(6, 1'b0);

        // Round-robin with only lane 2 active.
        cyc(4'h4, 32'h00A5_0000, 1'b0);
        cyc(4'h4, 32'h00A6_0000, 1'b0);
        idle(4, 1'b0);

        // TDM, single word on lane 1.
        cyc(4'h2, 32'h0000_5500, 1'b1);
        idle(8, 1'b1);

        // TDM overflow on lane 0.
        for (int i = 0; i < 12; i++) cyc(4'h1, 32'(8'(i + 1)), 1'b1);
        idle(20, 1'b1);

        // Reset while three lanes hold data.
        for (int i = 0; i < 4; i++) cyc(4'h7, $urandom, 1'b0);
        set_rst(1'b0);
        idle(2, 1'b0);
        set_rst(1'b1);
        idle(10, 1'b0);

        // Random traffic with mode changes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic m;
            m = ((i / 97) % 2) == 1;
            if ($urandom_range(0, 499) == 0) begin
                set_rst(1'b0);
                idle(2, m);
                set_rst(1'b1);
            end else begin
                cyc(4'($urandom) & 4'($urandom | $urandom), $urandom, m);
            end
        end
        idle(30, 1'b0);

        @(posedge clk_4f);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_nx1.md
# mux_rr_nx1

Parametrised N-to-1 lane multiplexer with per-lane buffering and round-robin or fixed-slot (TDM) output scheduling. It is the successor to the fixed 2:1 valid-qualified byte mux in the lane-combining path. It collapses `LANES` valid-qualified input lanes into one registered output lane on the fast clock, and tags each output word with its source lane. Per-lane FIFOs absorb bursts; full and overflow flags give upstream visibility.

## Interface
- `WIDTH`, 8: data width per lane and at the output.
- `LANES`, 4: number of input lanes; must be ≥2.
- `DEPTH`, 4: entries per lane FIFO; must be a power of two and ≥2.
- `clk_4f`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Entrada`  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- `validEntrada`  in  LANES  bit i qualifies lane i.
- `modo_tdm`  in  1  0 = work-conserving round-robin; 1 = fixed-slot TDM.
- `Salida`  out  WIDTH  registered output word.
- `validsalida`  out  1  registered; qualifies `Salida`.
- `lane_id`  out  clog2(LANES)  registered source lane of the current slot.
- `full`  out  LANES  bit i is high when lane i's FIFO holds DEPTH entries.
- `overflow`  out  LANES  sticky; bit i sets when lane i's data is dropped.

## Operation
- **Lane write:** a lane's word is pushed when its `validEntrada[i]` is 1 and its `full[i]` is 0, with `full` taken from the pre-edge count.
  - A write to a full lane is dropped and sets `overflow[i]`, even if the same lane pops in that cycle.
- **No bypass:** a word written in cycle k cannot be popped in cycle k.
- **Round-robin mode (`modo_tdm`=0):**
  - Scan lanes cyclically starting at pointer `ptr` and pick the first non-empty one.
  - Pop it and register its head word into `Salida`, with `validsalida`=1 and `lane_id` set to the chosen lane.
  - Then `ptr` ← chosen+1 mod LANES.
  - If all lanes are empty: `validsalida`=0, and `Salida`, `lane_id` and `ptr` hold their values.
- **TDM mode (`modo_tdm`=1):**
  - The slot lane is `ptr`, and `lane_id` ← `ptr` every cycle.
  - If that lane is non-empty: pop it, `Salida` ← head, `validsalida`=1.
  - If it is empty: `validsalida`=0 and `Salida` holds.
  - `ptr` ← `ptr`+1 mod LANES unconditionally.
- **Mode change:** `modo_tdm` is sampled every cycle and takes effect on the selection in that same cycle. `ptr` carries over with no flush.
- **Consumer:** the output has no backpressure; the consumer accepts every valid word.
- **Pointer arithmetic:** `ptr` wraps modulo LANES, including for LANES not a power of two. Each FIFO's read and write pointers are clog2(DEPTH)+1 bits, with the wrap bit used to tell full from empty.
- **Overflow clearing:** the `overflow` bits clear only on reset.

## Timing
- **Reset** (async assert, sync-released externally):
  - `Salida`=0, `validsalida`=0, `lane_id`=0.
  - `ptr`=0, all FIFOs empty, `full`=0, `overflow`=0.
- **Latency:** input accepted at edge k is eligible at cycle k+1 and appears on `Salida` after edge k+1, i.e. 2 cycles from input to output.
- **Throughput:**
  - One word per cycle total.
  - Sustained per-lane input above 1/LANES (TDM) or above the fair share (round-robin) fills the FIFO, then sets `full`, then drops.
- **`full[i]`** updates the cycle after the push or pop that changes the count.
- **Reset mid-operation:** buffered data is discarded immediately and the outputs go to their reset values asynchronously.
- **Simultaneous push and pop on the same lane with 0 < count < DEPTH:** the count is unchanged and the data order is preserved.

## Structure
- Shared package `mux_defs`:
  - mode encodings `MODO_RR`=0 and `MODO_TDM`=1;
  - default `WIDTH` and `LANES`;
  - a clog2 helper function.
- Sub-module `lane_fifo` (parameters `WIDTH`, `DEPTH`; ports: push, pop, din, dout, empty, full), instantiated LANES times through a generate loop.
- The top level holds the scheduler: `ptr`, the cyclic priority scan, the output registers and the overflow flags.

## Test plan
- **Reset:** hold `reset`=0 with random inputs → all outputs 0. Release, drive no valids for 10 cycles → `validsalida` stays 0 and `lane_id` stays 0.
- **Round-robin, all lanes active:** LANES=4, push 0x10, 0x20, 0x30, 0x40 on lanes 0–3 in one cycle.
  - Expect outputs 0x10, 0x20, 0x30, 0x40 on consecutive cycles, starting 2 cycles later, with `lane_id` 0, 1, 2, 3.
- **Round-robin skip:** only lane 2 holds 0xA5 and 0xA6 → two consecutive valid words, `lane_id`=2 twice. `ptr` ends at 3.
- **TDM:** `modo_tdm`=1, only lane 1 pushes 0x55 at cycle 0.
  - Expect `validsalida`=0 in the slots for lanes 0, 2 and 3.
  - Expect 0x55 in lane 1's first slot at or after cycle 1, and `lane_id` counting 0, 1, 2, 3, 0, … every cycle.
- **Overflow:** DEPTH=4, `modo_tdm`=1 with lane 0 pushing every cycle for 12 cycles.
  - `full[0]` rises.
  - Drops set `overflow[0]`, which stays 1 after the pushes stop.
  - The output carries only accepted words, in order, with no duplicates.
- **Reset mid-burst:** assert `reset` while 3 lanes hold data → everything is cleared. After release with no new input, `validsalida` stays 0.
